// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM states and op classifiers.
// Op codes 0..13 also give the order of the single-cycle result-select mux.
package alu_iter_pkg;

  localparam int OP_W = 5;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD  = 5'd0;
  localparam op_t OP_SUB  = 5'd1;
  localparam op_t OP_SLT  = 5'd2;
  localparam op_t OP_SLTU = 5'd3;
  localparam op_t OP_AND  = 5'd4;
  localparam op_t OP_NOR  = 5'd5;
  localparam op_t OP_OR   = 5'd6;
  localparam op_t OP_XOR  = 5'd7;
  localparam op_t OP_NXOR = 5'd8;
  localparam op_t OP_SLL  = 5'd9;
  localparam op_t OP_SRL  = 5'd10;
  localparam op_t OP_SRA  = 5'd11;
  localparam op_t OP_LUI  = 5'd12;
  localparam op_t OP_HUI  = 5'd13;
  localparam op_t OP_MUL  = 5'd14;
  localparam op_t OP_MULU = 5'd15;
  localparam op_t OP_DIV  = 5'd16;
  localparam op_t OP_DIVU = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_long(input op_t op);
    return (op >= OP_MUL) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_illegal(input op_t op);
    return op > OP_DIVU;
  endfunction

  function automatic logic is_signed_op(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the EX stage and the iterative ALU.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  import alu_iter_pkg::*;

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds its payload steady until then, and the consumer may
  // change ready freely. Operands transfer on in_*, results on out_*.
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             illegal;

  modport master (
    output in_valid, op, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, result_hi, illegal
  );

  modport slave (
    input  in_valid, op, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, result_hi, illegal
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Shared iterative engine: shift-add multiply or restoring divide on magnitudes,
// one step per cycle, with sign correction applied combinationally on the outputs.
module alu_iter_muldiv #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic             i_step,
  input  logic [SHW-1:0]   i_cnt,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0]   r_hi, r_lo, r_mcand;
  logic               r_is_div, r_neg_lo, r_neg_hi, r_div_zero;

  logic               w_neg1, w_neg2;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_madd, w_rem, w_trial;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_neg1 = i_signed & i_src1[WIDTH-1];
  assign w_neg2 = i_signed & i_src2[WIDTH-1];
  assign w_abs1 = w_neg1 ? (~i_src1 + 1'b1) : i_src1;
  assign w_abs2 = w_neg2 ? (~i_src2 + 1'b1) : i_src2;

  // r_lo holds the multiplier (mul) or the dividend being shifted into quotient (div).
  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_rem   = {r_hi, r_lo[WIDTH-1]};
  assign w_trial = w_rem - {1'b0, r_mcand};

  assign o_done = i_step & (i_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_mcand    <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (i_start) begin
      r_hi       <= '0;
      r_lo       <= w_abs1;
      r_mcand    <= w_abs2;
      r_is_div   <= i_is_div;
      r_neg_lo   <= w_neg1 ^ w_neg2;
      r_neg_hi   <= i_is_div ? w_neg1 : (w_neg1 ^ w_neg2);
      r_div_zero <= i_is_div & (i_src2 == '0);
    end else if (i_step) begin
      if (r_is_div) begin
        r_hi <= w_trial[WIDTH] ? w_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin
        r_hi <= w_madd[WIDTH:1];
        r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod_neg = ~{r_hi, r_lo} + 1'b1;

  // Remainder takes the dividend's sign; a zero divisor forces an all-ones quotient.
  always_comb begin
    o_hi = r_hi;
    o_lo = r_lo;
    if (r_is_div) begin
      o_lo = r_div_zero ? '1 : (r_neg_lo ? (~r_lo + 1'b1) : r_lo);
      o_hi = r_neg_hi ? (~r_hi + 1'b1) : r_hi;
    end else if (r_neg_lo) begin
      {o_hi, o_lo} = w_prod_neg;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// mul/div behind a valid/ready handshake, with result hold and flush.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      resetn,
  alu_iter_if.slave bus,
  output state_t    o_dbg_state
);

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic             r_out_valid;
  logic             r_illegal;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;

  logic             w_accept, w_long, w_illegal, w_busy, w_last;
  logic             w_signed_op, w_div_op;
  logic             w_sub, w_slt, w_sltu;
  logic [WIDTH-1:0] w_b, w_single, w_sra, w_eng_hi, w_eng_lo;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_shamt;

  assign bus.in_ready = ~bus.flush &
                        ((r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready));
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_long       = is_long(bus.op);
  assign w_illegal    = is_illegal(bus.op);
  assign w_signed_op  = is_signed_op(bus.op);
  assign w_div_op     = is_div_op(bus.op);
  assign w_busy       = (r_state == ST_BUSY);

  // Shared adder: src1 + src2 for ADD, src1 + ~src2 + 1 for SUB and the compares.
  assign w_sub   = (bus.op != OP_ADD);
  assign w_b     = w_sub ? ~bus.src2 : bus.src2;
  assign w_sum   = {1'b0, bus.src1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
  assign w_slt   = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) ? bus.src1[WIDTH-1]
                                                            : w_sum[WIDTH-1];
  assign w_sltu  = ~w_sum[WIDTH];
  assign w_shamt = bus.src1[SHW-1:0];
  assign w_sra   = $signed(bus.src2) >>> w_shamt;

  always_comb begin
    w_single = '0;
    case (bus.op)
      OP_ADD,
      OP_SUB:  w_single = w_sum[WIDTH-1:0];
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_AND:  w_single = bus.src1 & bus.src2;
      OP_NOR:  w_single = ~(bus.src1 | bus.src2);
      OP_OR:   w_single = bus.src1 | bus.src2;
      OP_XOR:  w_single = bus.src1 ^ bus.src2;
      OP_NXOR: w_single = ~(bus.src1 ^ bus.src2);
      OP_SLL:  w_single = bus.src2 << w_shamt;
      OP_SRL:  w_single = bus.src2 >> w_shamt;
      OP_SRA:  w_single = w_sra;
      OP_LUI:  w_single = {bus.src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_HUI:  w_single = {{(WIDTH/2){1'b0}}, bus.src2[WIDTH/2-1:0]};
      default: w_single = '0;
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .resetn   (resetn),
    .i_start  (w_accept & w_long),
    .i_signed (w_signed_op),
    .i_is_div (w_div_op),
    .i_src1   (bus.src1),
    .i_src2   (bus.src2),
    .i_step   (w_busy),
    .i_cnt    (r_cnt),
    .o_done   (w_last),
    .o_hi     (w_eng_hi),
    .o_lo     (w_eng_lo)
  );

  // Flush wins over both a new accept and the consumer taking the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
    end else if (bus.flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_long) begin
              r_state     <= ST_BUSY;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single;
              r_result_hi <= '0;
              r_illegal   <= w_illegal;
            end
          end else if ((r_state == ST_DONE) && bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_FIX;
            r_cnt   <= '0;
          end
        end
        ST_FIX: begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_eng_lo;
          r_result_hi <= w_eng_hi;
          r_illegal   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.illegal   = r_illegal;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized checks of alu_iter against a plain-arithmetic reference model.
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W = 32;

  logic   clk = 1'b0;
  logic   resetn;
  state_t dbg_state;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: {illegal, hi, lo} from ordinary 64-bit arithmetic.
  function automatic logic [64:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] lo, hi;
    logic [63:0] p;
    longint      sa, sb;
    lo = '0;
    hi = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_SLT:  lo = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: lo = (a < b) ? 32'd1 : 32'd0;
      OP_AND:  lo = a & b;
      OP_NOR:  lo = ~(a | b);
      OP_OR:   lo = a | b;
      OP_XOR:  lo = a ^ b;
      OP_NXOR: lo = ~(a ^ b);
      OP_SLL:  lo = b << a[4:0];
      OP_SRL:  lo = b >> a[4:0];
      OP_SRA:  lo = 32'(sb >>> a[4:0]);
      OP_LUI:  lo = {b[15:0], 16'h0000};
      OP_HUI:  lo = {16'h0000, b[15:0]};
      OP_MUL: begin
        p = sa * sb;
        {hi, lo} = p;
      end
      OP_MULU: begin
        p = {32'h0, a} * {32'h0, b};
        {hi, lo} = p;
      end
      OP_DIV: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: return {1'b1, 64'h0};
    endcase
    return {1'b0, hi, lo};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [64:0] exp_v;
    int          lat, guard, exp_lat;
    logic        ready_seen;
    @(negedge clk);
    bus.op        = op;
    bus.src1      = a;
    bus.src2      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, 66'(bus.in_ready), 66'd1);
    @(posedge clk);
    exp_q.push_back(ref_model(op, a, b));
    #1 bus.in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) ready_seen = 1'b1;
    end while (!bus.out_valid && lat < 60);
    exp_lat = (op >= 5'd14 && op <= 5'd17) ? (W + 2) : 1;
    check({tag, "_latency"}, 66'(lat), 66'(exp_lat));
    if (exp_lat > 1) check({tag, "_ready_busy"}, 66'(ready_seen), 66'd0);
    exp_v = exp_q.pop_front();
    check({tag, "_result"}, 66'({bus.illegal, bus.result_hi, bus.result}), 66'(exp_v));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  66'(bus.in_ready),  66'd1);
    check({tag, "_out_valid"}, 66'(bus.out_valid), 66'd0);
    check({tag, "_result"},    66'(bus.result),    66'd0);
    check({tag, "_result_hi"}, 66'(bus.result_hi), 66'd0);
    check({tag, "_illegal"},   66'(bus.illegal),   66'd0);
    check({tag, "_state"},     66'(dbg_state),     66'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [4:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [64:0] r_exp;
  logic        r_seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    resetn        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;

    // Directed single-cycle ops
    run_op(OP_ADD,  32'hFFFF_FFFF, 32'h1,         "add_wrap");
    run_op(OP_SRA,  32'h4,         32'h8000_0000, "sra_neg");
    run_op(OP_SLTU, 32'h1,         32'hFFFF_FFFF, "sltu");
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'h1,         "slt_neg");

    // Directed mul/div corners
    run_op(OP_MUL,  32'hFFFF_FFFD, 32'h7,         "mul_neg");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h2,         "div_neg");
    run_op(OP_DIVU, 32'h5,         32'h0,         "divu_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0,         "div_zero_neg");

    // Flush in the middle of a MULU
    @(negedge clk);
    bus.op        = OP_MULU;
    bus.src1      = $urandom();
    bus.src2      = $urandom();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_ready_low", 66'(bus.in_ready), 66'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_idle_state", 66'(dbg_state),     66'(ST_IDLE));
    check("flush_idle_ready", 66'(bus.in_ready),  66'd1);
    r_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) r_seen = 1'b1;
    end
    check("flush_no_valid", 66'(r_seen), 66'd0);
    run_op(OP_ADD, 32'h0000_1234, 32'h0000_4321, "post_flush_add");

    // Undefined op code
    run_op(5'd20, 32'hDEAD_BEEF, 32'h1234_5678, "illegal_op");

    // Result hold under back-pressure, then back-to-back accept
    @(negedge clk);
    bus.op        = OP_XOR;
    bus.src1      = 32'hA5A5_0F0F;
    bus.src2      = 32'h0FF0_1234;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    r_exp = ref_model(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_1234);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("hold_first", 66'({bus.out_valid, bus.illegal, bus.result_hi, bus.result}),
          {1'b1, r_exp});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 66'({bus.out_valid, bus.illegal, bus.result_hi, bus.result}),
            {1'b1, r_exp});
    end
    r_a           = $urandom();
    bus.op        = OP_LUI;
    bus.src1      = r_a;
    bus.src2      = 32'h0000_1234;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("b2b_ready", 66'(bus.in_ready), 66'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_lui", 66'({bus.out_valid, bus.illegal, bus.result_hi, bus.result}),
          {1'b1, 1'b0, 32'h0, 32'h1234_0000});

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    bus.op       = OP_DIV;
    bus.src1     = 32'h0123_4567;
    bus.src2     = 32'h0000_0089;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset_busy", 66'(dbg_state), 66'(ST_BUSY));
    #2 resetn = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    resetn = 1'b1;

    // Randomized ops over the whole op-code space
    for (int i = 0; i < 24; i++) begin
      r_op = 5'($urandom_range(0, 31));
      r_a  = rand_operand();
      r_b  = rand_operand();
      run_op(r_op, r_a, r_b, $sformatf("rand%0d_op%0d", i, r_op));
    end

    // One single-cycle op per clock with out_ready held high
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_op = 5'($urandom_range(0, 13));
      r_a  = rand_operand();
      r_b  = rand_operand();
      bus.op       = r_op;
      bus.src1     = r_a;
      bus.src2     = r_b;
      bus.in_valid = 1'b1;
      #1 check("stream_ready", 66'(bus.in_ready), 66'd1);
      @(posedge clk);
      exp_q.push_back(ref_model(r_op, r_a, r_b));
      @(negedge clk);
      r_exp = exp_q.pop_front();
      check($sformatf("stream%0d_op%0d", i, r_op),
            66'({bus.out_valid, bus.illegal, bus.result_hi, bus.result}), {1'b1, r_exp});
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, multi-cycle successor to the single-cycle ALU. Executes all 14 existing logic/arith/shift ops in one registered cycle and adds iterative signed/unsigned multiply and divide with a WIDTH-cycle engine. Sits in the EX stage of the multi-cycle CPU behind a valid/ready handshake so the stage can stall on long ops. Results are held until consumed, and a flush kills an in-flight op.

## Interface
- WIDTH, 32: operand/result width; power of 2, ≥8.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  op + operands presented.
- in_ready  output  1  block can accept this cycle.
- op  input  5  operation code (alu_pkg encoding).
- src1  input  WIDTH  operand 1; shift amount = src1[SHW-1:0].
- src2  input  WIDTH  operand 2; shifted value / immediate source.
- flush  input  1  synchronous kill of pending/in-flight op.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  main result (mul low, div quotient).
- result_hi  output  WIDTH  mul high half / div remainder; 0 for other ops.
- illegal  output  1  with out_valid: op code undefined, results 0.

## Operation
- Ops 0–13: ADD, SUB, SLT, SLTU, AND, NOR, OR, XOR, NXOR, SLL, SRL, SRA, LUI, HUI. Semantics identical to current ALU, scaled to WIDTH. LUI = {src2[WIDTH/2-1:0], 0}; HUI = {0, src2[WIDTH/2-1:0]}. SLT/SLTU use the adder's sign/carry; results are 0/1.
- Ops 14–17: MUL, MULU, DIV, DIVU. {result_hi,result} = full 2·WIDTH product. DIV/DIVU: result = quotient truncated toward zero; result_hi = remainder, sign of dividend.
- Div by zero: result = all ones, result_hi = src1. Signed MIN / −1: result = MIN, result_hi = 0.
- Ops 18–31: illegal = 1, single-cycle path.
- FSM: IDLE → (accept single-cycle op) → DONE. IDLE → (accept mul/div) → BUSY.
- BUSY: counter 0..WIDTH-1, one shift-add / restoring-subtract step per cycle, then FIX.
- FIX: one cycle that applies result signs, then DONE.
- DONE → IDLE on out_ready. If in_valid is also high on that cycle, go directly to the next op's state (back-to-back).
- Signed mul/div take absolute values at accept and negate in FIX.
- Any state + flush → IDLE next edge. out_valid drops; the engine result is discarded. Flush has priority over accept and over out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, result_hi=0, illegal=0, state=IDLE, counter=0.
- Accept = in_valid & in_ready on a rising edge; operands are sampled only then.
- in_ready = (state==IDLE) | (state==DONE & out_ready); in_ready is low during flush.
- Single-cycle op latency: out_valid high the cycle after accept.
- Mul/div latency: out_valid high WIDTH+2 cycles after accept (1 setup merged into accept, WIDTH BUSY, 1 FIX).
- result, result_hi, illegal are stable while out_valid & ~out_ready; the hold is unbounded.
- Throughput: one single-cycle op per clock with out_ready tied high.
- resetn low mid-op aborts immediately and asynchronously. No output glitch beyond the reset values.

## Structure
- alu_pkg: op code constants (5-bit), FSM state encoding, the is_long(op) function, and the result-select mux ordering.
- Sub-module alu_muldiv_iter: the shared iterative engine. Interface: start, signed, is_div, operands, step counter, done, {hi,lo}. The FSM and the single-cycle datapath stay in alu_iter.
- Reuse the existing adder module for add/sub/slt/sltu.

## Test plan
- WIDTH=32, op=ADD, src1=0xFFFFFFFF, src2=1, out_ready=1 → next cycle out_valid=1, result=0, result_hi=0.
- op=SRA, src1=4, src2=0x80000000 → result=0xF8000000. op=SLTU, src1=1, src2=0xFFFFFFFF → result=1.
- op=MUL, src1=−3, src2=7 → out_valid exactly 34 cycles after accept. result=0xFFFFFFEB, result_hi=0xFFFFFFFF. in_ready=0 throughout BUSY/FIX.
- op=DIV, src1=−7, src2=2 → result=0xFFFFFFFD, result_hi=0xFFFFFFFF. DIVU 5/0 → result=0xFFFFFFFF, result_hi=5. DIV 0x80000000/−1 → result=0x80000000, result_hi=0.
- MULU accepted, flush at BUSY cycle 10 → out_valid never asserts; IDLE and in_ready=1 next cycle. A new ADD is accepted and completes normally.
- Hold out_ready=0 for 5 cycles after an XOR result → outputs unchanged. Then assert out_ready with in_valid=1 (op=LUI, src2=0x1234) → back-to-back accept; next result=0x12340000. Also: op=20 → illegal=1, result=0; resetn pulse mid-DIV → reset values.
